// File: rtl/hazard_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_mc_if
// Purpose  : Decode-stage hazard interface. Carries the D-stage operand and
//            load information into the hazard unit, and the stall/bubble/freeze
//            controls and statistics back out.
// Signals  : d_valid, d_src_addr, d_src_used, d_memread, d_dst_reg,
//            ex_flush, mem_busy          (master -> slave)
//            stall, bubble, freeze, hazard_src, stall_cnt (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_mc_if #(
   parameter int REG_ADDR = 5,
   parameter int NUM_SRC  = 2,
   parameter int CNT_W    = 16
);
   logic                         d_valid;
   logic [NUM_SRC*REG_ADDR-1:0]  d_src_addr;
   logic [NUM_SRC-1:0]           d_src_used;
   logic                         d_memread;
   logic [REG_ADDR-1:0]          d_dst_reg;
   logic                         ex_flush;
   logic                         mem_busy;
   logic                         stall;
   logic                         bubble;
   logic                         freeze;
   logic [NUM_SRC-1:0]           hazard_src;
   logic [CNT_W-1:0]             stall_cnt;

   modport master (
      output d_valid, d_src_addr, d_src_used, d_memread, d_dst_reg, ex_flush, mem_busy,
      input  stall, bubble, freeze, hazard_src, stall_cnt
   );

   modport slave (
      input  d_valid, d_src_addr, d_src_used, d_memread, d_dst_reg, ex_flush, mem_busy,
      output stall, bubble, freeze, hazard_src, stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_mc
// Purpose  : Multi-cycle load-use hazard unit. Tracks loads for LOAD_LAT
//            cycles after they leave D and stalls a dependent D instruction
//            until the load result becomes forwardable. Filters r0, honours
//            branch flushes, freezes the whole pipe while memory is busy and
//            keeps a saturating count of stall cycles.
// Ports    : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset
//            hz        - hazard_ctrl_mc_if.slave (D-stage inputs, controls out)
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_mc #(
   parameter int REG_ADDR = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   hazard_ctrl_mc_if.slave    hz
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   // Tracker: entry 0 is the youngest load; entry LOAD_LAT-1 retires next.
   logic [LOAD_LAT-1:0]                r_v;
   logic [LOAD_LAT-1:0][REG_ADDR-1:0]  r_dst;
   logic [CNT_W-1:0]                   r_stall_cnt;

   logic [NUM_SRC-1:0]                 w_match;
   logic [NUM_SRC-1:0]                 w_hazard;
   logic                               w_stall;
   logic                               w_push;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_ADDR-1:0] w_src;
      logic [LOAD_LAT-1:0] w_hit;

      assign w_src = hz.d_src_addr[i*REG_ADDR +: REG_ADDR];

      for (genvar k = 0; k < LOAD_LAT; k++) begin : g_ent
         assign w_hit[k] = r_v[k] & (r_dst[k] == w_src);
      end

      // r0 is hard-wired zero, so it never depends on a load.
      assign w_match[i] = hz.d_valid & hz.d_src_used[i] & (w_src != '0) & (|w_hit);
   end

   // mem_busy dominates everything, then a flush squashes the D instruction.
   assign w_hazard = w_match & {NUM_SRC{~hz.mem_busy & ~hz.ex_flush}};
   assign w_stall  = |w_hazard;

   // A stalled load stays in D and is only entered once its own stall clears.
   assign w_push = hz.d_valid & hz.d_memread & ~w_stall & ~hz.ex_flush &
                   (hz.d_dst_reg != '0);

   assign hz.hazard_src = w_hazard;
   assign hz.stall      = w_stall;
   assign hz.bubble     = w_stall;
   assign hz.freeze     = hz.mem_busy;
   assign hz.stall_cnt  = r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v         <= '0;
         r_dst       <= '0;
         r_stall_cnt <= '0;
      end else if (!hz.mem_busy) begin
         for (int k = LOAD_LAT - 1; k > 0; k--) begin
            r_v[k]   <= r_v[k-1];
            r_dst[k] <= r_dst[k-1];
         end
         r_v[0]   <= w_push;
         r_dst[0] <= hz.d_dst_reg;
         if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_mc
// Purpose  : Directed self-checking bench for hazard_ctrl_mc with LOAD_LAT=2,
//            NUM_SRC=2 and a 2-bit stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_mc;

   localparam int REG_ADDR = 5;
   localparam int NUM_SRC  = 2;
   localparam int LOAD_LAT = 2;
   localparam int CNT_W    = 2;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   hazard_ctrl_mc_if #(.REG_ADDR(REG_ADDR), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) hz ();

   hazard_ctrl_mc #(
      .REG_ADDR (REG_ADDR),
      .NUM_SRC  (NUM_SRC),
      .LOAD_LAT (LOAD_LAT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {freeze, stall, bubble, hazard_src}
   logic [4:0] obs;
   assign obs = {hz.freeze, hz.stall, hz.bubble, hz.hazard_src};

   // Saturation sequence: expected stall and counter in cycles 1..8.
   int exp_stall [1:8] = '{1, 1, 0, 1, 1, 0, 1, 1};
   int exp_cnt   [1:8] = '{0, 1, 2, 2, 3, 3, 3, 3};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic mr, input logic [4:0] dst,
                        input logic fl, input logic bz);
      hz.d_valid    = v;
      hz.d_src_addr = {s1, s0};
      hz.d_src_used = used;
      hz.d_memread  = mr;
      hz.d_dst_reg  = dst;
      hz.ex_flush   = fl;
      hz.mem_busy   = bz;
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
      total++;
      if (obs !== 5'b0_00_00 || hz.stall_cnt !== 2'd0) begin
         bad++;
         $display("FAIL reset_outputs: got flags=%b cnt=%0d want flags=00000 cnt=0", obs, hz.stall_cnt);
      end
      drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b1);
      total++;
      if (obs !== 5'b1_00_00) begin
         bad++;
         $display("FAIL reset_freeze: got flags=%b want 10000", obs);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_basic_stall();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 1'b0, 1'b0);   // load r5
      total++;
      if (obs !== 5'b0_00_00) begin
         bad++;
         $display("FAIL basic_load_nostall: got flags=%b want 00000", obs);
      end
      tick();
      drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);   // reader of r5
      for (int c = 0; c < 2; c++) begin
         total++;
         if (obs !== 5'b0_11_01) begin
            bad++;
            $display("FAIL basic_stall_c%0d: got flags=%b want 01101", c, obs);
         end
         tick();
      end
      total++;
      if (obs !== 5'b0_00_00 || hz.stall_cnt !== 2'd2) begin
         bad++;
         $display("FAIL basic_release: got flags=%b cnt=%0d want flags=00000 cnt=2", obs, hz.stall_cnt);
      end
   endtask

   task automatic test_gap();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);   // independent
      total++;
      if (obs !== 5'b0_00_00) begin
         bad++;
         $display("FAIL gap_independent: got flags=%b want 00000", obs);
      end
      tick();
      drive(1'b1, 5'd0, 5'd5, 2'b10, 1'b0, 5'd0, 1'b0, 1'b0);   // r5 as src1
      total++;
      if (obs !== 5'b0_11_10) begin
         bad++;
         $display("FAIL gap_stall: got flags=%b want 01110", obs);
      end
      tick();
      total++;
      if (obs !== 5'b0_00_00 || hz.stall_cnt !== 2'd1) begin
         bad++;
         $display("FAIL gap_release: got flags=%b cnt=%0d want flags=00000 cnt=1", obs, hz.stall_cnt);
      end
   endtask

   task automatic test_filters();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b0, 1'b0);   // load r0
      tick();
      drive(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 1'b0, 1'b0);   // reads r0
      total++;
      if (obs !== 5'b0_00_00) begin
         bad++;
         $display("FAIL r0_filter: got flags=%b want 00000", obs);
      end
      tick();
      drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 1'b0, 1'b0);   // load r6
      tick();
      drive(1'b1, 5'd3, 5'd6, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);   // r6 on unused src1
      total++;
      if (obs !== 5'b0_00_00) begin
         bad++;
         $display("FAIL unused_operand: got flags=%b want 00000", obs);
      end
      tick();
      drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b0, 1'b0);   // load r9
      tick();
      drive(1'b1, 5'd9, 5'd9, 2'b11, 1'b0, 5'd0, 1'b0, 1'b0);   // both read r9
      total++;
      if (obs !== 5'b0_11_11) begin
         bad++;
         $display("FAIL both_operands: got flags=%b want 01111", obs);
      end
   endtask

   task automatic test_freeze();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();                                                    // one stall cycle counted
      drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b1);   // memory busy
      for (int c = 0; c < 3; c++) begin
         total++;
         if (obs !== 5'b1_00_00 || hz.stall_cnt !== 2'd1) begin
            bad++;
            $display("FAIL freeze_c%0d: got flags=%b cnt=%0d want flags=10000 cnt=1", c, obs, hz.stall_cnt);
         end
         tick();
      end
      drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);
      total++;
      if (obs !== 5'b0_11_01) begin
         bad++;
         $display("FAIL freeze_resume: got flags=%b want 01101", obs);
      end
      tick();
      total++;
      if (obs !== 5'b0_00_00 || hz.stall_cnt !== 2'd2) begin
         bad++;
         $display("FAIL freeze_done: got flags=%b cnt=%0d want flags=00000 cnt=2", obs, hz.stall_cnt);
      end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 1'b1, 1'b0);   // hazard + flush
      total++;
      if (obs !== 5'b0_00_00) begin
         bad++;
         $display("FAIL flush_suppress: got flags=%b want 00000", obs);
      end
      tick();
      drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);   // entry now oldest
      total++;
      if (obs !== 5'b0_11_01) begin
         bad++;
         $display("FAIL flush_tracker_kept: got flags=%b want 01101", obs);
      end
      do_reset();
      drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd8, 1'b1, 1'b0);   // flushed load
      tick();
      drive(1'b1, 5'd8, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0);
      total++;
      if (obs !== 5'b0_00_00 || hz.stall_cnt !== 2'd0) begin
         bad++;
         $display("FAIL flushed_load_untracked: got flags=%b cnt=%0d want flags=00000 cnt=0", obs, hz.stall_cnt);
      end
   endtask

   task automatic test_saturate_and_reset();
      do_reset();
      // Repeated "load r5 reading r5": stalls twice, then is pushed, and so on.
      drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b1, 5'd5, 1'b0, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         total++;
         if (int'(hz.stall) !== exp_stall[c] || int'(hz.stall_cnt) !== exp_cnt[c]) begin
            bad++;
            $display("FAIL saturate_c%0d: got stall=%0d cnt=%0d want stall=%0d cnt=%0d",
                     c, hz.stall, hz.stall_cnt, exp_stall[c], exp_cnt[c]);
         end
      end
      #2;
      rst_n = 1'b0;                                              // mid-cycle, no clock edge
      #1;
      total++;
      if (hz.stall !== 1'b0 || hz.bubble !== 1'b0 || hz.stall_cnt !== 2'd0) begin
         bad++;
         $display("FAIL async_reset_midstall: got stall=%b bubble=%b cnt=%0d want 0 0 0",
                  hz.stall, hz.bubble, hz.stall_cnt);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      test_reset();
      test_basic_stall();
      test_gap();
      test_filters();
      test_freeze();
      test_flush();
      test_saturate_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
